// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding a start/data/stop serialiser.
// Writes while the FIFO is full are dropped and latch the sticky overflow flag.
module uart_tx_buffered #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic             empty,
  output logic [FIFO_AW:0] fill,
  output logic             overflow,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);
  localparam int unsigned       Depth     = 2 ** FIFO_AW;
  localparam int unsigned       CntW      = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0]   CntLast   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]   CntPenult = CntW'(CLKS_PER_BIT - 2);
  localparam logic [FIFO_AW:0]  FillMax   = (FIFO_AW + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e             state;
  logic [CntW-1:0]    cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;

  logic [7:0]         mem [Depth];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   fill_next;
  logic               push;
  logic               pop;
  logic               bit_end;

  assign bit_end = (cnt == CntLast);
  assign push    = wr_en && !full;
  // The serialiser pops from IDLE, or on the last stop-bit cycle for gapless frames.
  assign pop     = !empty && ((state == StIdle) || ((state == StStop) && bit_end));

  always_comb begin
    fill_next = fill;
    if (push && !pop) begin
      fill_next = fill + 1'b1;
    end else if (pop && !push) begin
      fill_next = fill - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fill  <= fill_next;
      full  <= (fill_next == FillMax);
      empty <= (fill_next == '0);
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        StIdle: begin
          cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= StStart;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        StStart: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= StData;
            tx      <= shift[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StData: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= StStop;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StStop: begin
          // Registered, so raise it one cycle early to land on the final stop cycle.
          tx_done <= (cnt == CntPenult);
          if (bit_end) begin
            cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= StStart;
              tx    <= 1'b0;
            end else begin
              state <= StIdle;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
